// File: rtl/pcss_node_pkg.sv
// Shared definitions for the node controllers: FSM encodings, spike-code values
// and the per-axis coordinate width derived from the spike-id width.
package pcss_node_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } scan_state_t;

    localparam logic [1:0] CODE_LIF      = 2'd0;
    localparam logic [1:0] CODE_COUNT    = 2'd1;
    localparam logic [1:0] CODE_POISSON  = 2'd2;
    localparam logic [1:0] CODE_RESERVED = 2'd3;

    // Spike ids are {z,y,x} with equal-width fields.
    function automatic int coord_width(input int sw);
        return sw / 3;
    endfunction

endpackage

// File: rtl/tik_edge_sync.sv
// Brings the asynchronous tik strobe into the clk domain and flags its falling edge.
module tik_edge_sync #(
    parameter int SYNC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tik,
    output logic tik_fall
);

    logic [SYNC-1:0] d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg <= '0;
        end else begin
            d_reg <= {d_reg[SYNC-2:0], tik};
        end
    end

    // The two oldest stages are already metastability-free.
    assign tik_fall = d_reg[SYNC-1] & ~d_reg[SYNC-2];

endmodule

// File: rtl/neu_scan_ctrl.sv
// Per-timestep neuron scan controller: walks every neuron once per tik fall with
// 3-D coordinate stepping, queues one early start, and runs the config-time clear sweep.
module neu_scan_ctrl
    import pcss_node_pkg::*;
#(
    parameter int NNW        = 12,
    parameter int SW         = 24,
    parameter int CODE_WIDTH = 2,
    parameter int SYNC       = 3,
    localparam int CW        = coord_width(SW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tik,
    input  logic                  config_enable,
    input  logic                  config_clear,
    input  logic [CODE_WIDTH-1:0] spike_code,
    input  logic [NNW-1:0]        neu_num,
    input  logic [CW-1:0]         x_out,
    input  logic [CW-1:0]         y_out,
    input  logic [CW-1:0]         z_num,
    input  logic [CW-1:0]         x_start,
    input  logic [CW-1:0]         y_start,
    input  logic [CW-1:0]         z_start,
    input  logic                  neu_rdy,
    output logic                  neu_vld,
    output logic [NNW-1:0]        neu_addr,
    output logic [CODE_WIDTH-1:0] neu_mode,
    output logic                  neu_clear,
    output logic                  neu_last,
    output logic [SW-1:0]         neu_spkid,
    output logic                  scan_start,
    output logic                  scan_done,
    output logic                  clear_done,
    output logic                  tik_overrun,
    output logic                  busy
);

    localparam logic [CODE_WIDTH-1:0] CODE_RSVD = CODE_WIDTH'(CODE_RESERVED);

    scan_state_t           state_reg, state_next;
    logic [NNW-1:0]        addr_reg, addr_next;
    logic [CW-1:0]         x_reg, x_next;
    logic [CW-1:0]         y_reg, y_next;
    logic [CW-1:0]         z_reg, z_next;
    logic [CODE_WIDTH-1:0] mode_reg, mode_next;
    logic                  pend_reg, pend_next;
    logic                  scan_start_reg, scan_start_next;

    logic tik_fall;
    logic start;
    logic code_ok;
    logic at_last;

    tik_edge_sync #(.SYNC(SYNC)) u_tik_sync (
        .clk      (clk),
        .rst      (rst),
        .tik      (tik),
        .tik_fall (tik_fall)
    );

    assign start   = tik_fall & config_enable;
    assign code_ok = (spike_code != CODE_RSVD);
    assign at_last = (addr_reg == neu_num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            z_reg          <= '0;
            mode_reg       <= '0;
            pend_reg       <= 1'b0;
            scan_start_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            z_reg          <= z_next;
            mode_reg       <= mode_next;
            pend_reg       <= pend_next;
            scan_start_reg <= scan_start_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        z_next          = z_reg;
        mode_next       = mode_reg;
        pend_next       = pend_reg;
        scan_start_next = 1'b0;
        scan_done       = 1'b0;
        clear_done      = 1'b0;
        tik_overrun     = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start && code_ok) begin
                    state_next      = ST_RUN;
                    mode_next       = spike_code;
                    addr_next       = '0;
                    x_next          = '0;
                    y_next          = '0;
                    z_next          = '0;
                    pend_next       = 1'b0;
                    scan_start_next = 1'b1;
                end else if (!config_enable && config_clear) begin
                    state_next = ST_CLEAR;
                    addr_next  = '0;
                end
            end
            ST_RUN: begin
                if (!config_enable) begin
                    state_next = ST_IDLE;
                    pend_next  = 1'b0;
                    addr_next  = '0;
                    x_next     = '0;
                    y_next     = '0;
                    z_next     = '0;
                end else if (neu_rdy && at_last) begin
                    // A start landing on the final handshake counts as the queued one.
                    scan_done   = 1'b1;
                    tik_overrun = pend_reg & start;
                    pend_next   = 1'b0;
                    addr_next   = '0;
                    x_next      = '0;
                    y_next      = '0;
                    z_next      = '0;
                    if ((pend_reg || start) && code_ok) begin
                        mode_next       = spike_code;
                        scan_start_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (neu_rdy) begin
                        addr_next = addr_reg + 1'b1;
                        if (x_reg < x_out) begin
                            x_next = x_reg + 1'b1;
                        end else if (y_reg < y_out) begin
                            x_next = '0;
                            y_next = y_reg + 1'b1;
                        end else if (z_reg < z_num) begin
                            x_next = '0;
                            y_next = '0;
                            z_next = z_reg + 1'b1;
                        end else begin
                            x_next = '0;
                            y_next = '0;
                            z_next = '0;
                        end
                    end
                    if (start) begin
                        if (pend_reg) begin
                            tik_overrun = 1'b1;
                        end else begin
                            pend_next = 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                if (at_last) begin
                    clear_done = 1'b1;
                    state_next = ST_IDLE;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy       = (state_reg != ST_IDLE);
    assign neu_vld    = busy;
    assign neu_clear  = (state_reg == ST_CLEAR);
    assign neu_last   = neu_vld & at_last;
    assign neu_addr   = addr_reg;
    assign neu_mode   = mode_reg;
    assign scan_start = scan_start_reg;
    assign neu_spkid  = (state_reg == ST_RUN) ?
                        {z_start + z_reg, y_start + y_reg, x_start + x_reg} : '0;

endmodule

// File: tb/tb_neu_scan_ctrl.sv
// Scoreboard bench for neu_scan_ctrl: expected issues come from a mixed-radix
// model of the scan order; a forked monitor checks every valid cycle against it.
module tb_neu_scan_ctrl;
    import pcss_node_pkg::*;

    localparam int NNW        = 12;
    localparam int SW         = 24;
    localparam int CODE_WIDTH = 2;
    localparam int SYNC       = 3;
    localparam int CW         = SW / 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  tik;
    logic                  config_enable;
    logic                  config_clear;
    logic [CODE_WIDTH-1:0] spike_code;
    logic [NNW-1:0]        neu_num;
    logic [CW-1:0]         x_out, y_out, z_num;
    logic [CW-1:0]         x_start, y_start, z_start;
    logic                  neu_rdy;
    logic                  neu_vld;
    logic [NNW-1:0]        neu_addr;
    logic [CODE_WIDTH-1:0] neu_mode;
    logic                  neu_clear;
    logic                  neu_last;
    logic [SW-1:0]         neu_spkid;
    logic                  scan_start;
    logic                  scan_done;
    logic                  clear_done;
    logic                  tik_overrun;
    logic                  busy;

    always #5 clk = ~clk;

    neu_scan_ctrl #(.NNW(NNW), .SW(SW), .CODE_WIDTH(CODE_WIDTH), .SYNC(SYNC)) dut (
        .clk(clk), .rst(rst), .tik(tik),
        .config_enable(config_enable), .config_clear(config_clear),
        .spike_code(spike_code), .neu_num(neu_num),
        .x_out(x_out), .y_out(y_out), .z_num(z_num),
        .x_start(x_start), .y_start(y_start), .z_start(z_start),
        .neu_rdy(neu_rdy), .neu_vld(neu_vld), .neu_addr(neu_addr),
        .neu_mode(neu_mode), .neu_clear(neu_clear), .neu_last(neu_last),
        .neu_spkid(neu_spkid), .scan_start(scan_start), .scan_done(scan_done),
        .clear_done(clear_done), .tik_overrun(tik_overrun), .busy(busy)
    );

    typedef struct {
        int                    addr;
        logic [SW-1:0]         spkid;
        bit                    last;
        bit                    clr;
        bit                    first;
        logic [CODE_WIDTH-1:0] mode;
    } item_t;

    item_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    done_seen = 0, cdone_seen = 0, ovr_seen = 0, vld_cycles = 0;
    bit    mon_en = 1'b0;
    bit    stalled = 1'b0;
    int    c_num, c_xo, c_yo, c_zn, c_xs, c_ys, c_zs;

    task automatic check(input bit ok, input string name, input string got, input string want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    task automatic apply_cfg();
        neu_num = NNW'(c_num);
        x_out   = CW'(c_xo);
        y_out   = CW'(c_yo);
        z_num   = CW'(c_zn);
        x_start = CW'(c_xs);
        y_start = CW'(c_ys);
        z_start = CW'(c_zs);
    endtask

    // Neuron i sits at mixed-radix digits of i with radices (x_out+1, y_out+1, z_num+1).
    task automatic push_scan(input logic [CODE_WIDTH-1:0] mode);
        item_t it;
        int nx, ny, nz;
        logic [CW-1:0] fx, fy, fz;
        nx = c_xo + 1;
        ny = c_yo + 1;
        nz = c_zn + 1;
        for (int i = 0; i <= c_num; i++) begin
            fx = CW'((c_xs + i % nx) % (1 << CW));
            fy = CW'((c_ys + (i / nx) % ny) % (1 << CW));
            fz = CW'((c_zs + (i / (nx * ny)) % nz) % (1 << CW));
            it.addr  = i;
            it.spkid = {fz, fy, fx};
            it.last  = (i == c_num);
            it.clr   = 1'b0;
            it.first = (i == 0);
            it.mode  = mode;
            exp_q.push_back(it);
        end
    endtask

    task automatic push_clear();
        item_t it;
        for (int i = 0; i <= c_num; i++) begin
            it.addr  = i;
            it.spkid = '0;
            it.last  = (i == c_num);
            it.clr   = 1'b1;
            it.first = 1'b0;
            it.mode  = '0;
            exp_q.push_back(it);
        end
    endtask

    task automatic monitor();
        item_t e;
        bit ok;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (tik_overrun) ovr_seen++;
                if (scan_done)   done_seen++;
                if (clear_done)  cdone_seen++;
                if (neu_vld) begin
                    vld_cycles++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_issue", $sformatf("vld addr=%0d", neu_addr), "no issue");
                    end else begin
                        e  = exp_q[0];
                        ok = (neu_addr == NNW'(e.addr)) && (neu_last == e.last) && (neu_clear == e.clr);
                        if (!e.clr) ok = ok && (neu_spkid == e.spkid) && (neu_mode == e.mode);
                        ok = ok && (scan_start == (e.first && !stalled));
                        ok = ok && (scan_done == (!e.clr && e.last && neu_rdy));
                        ok = ok && (clear_done == (e.clr && e.last));
                        check(ok, "issue",
                              $sformatf("addr=%0d spkid=%h mode=%0d last=%0b clr=%0b ss=%0b sd=%0b cd=%0b",
                                        neu_addr, neu_spkid, neu_mode, neu_last, neu_clear,
                                        scan_start, scan_done, clear_done),
                              $sformatf("addr=%0d spkid=%h mode=%0d last=%0b clr=%0b ss=%0b sd=%0b cd=%0b",
                                        e.addr, e.spkid, e.mode, e.last, e.clr, e.first && !stalled,
                                        !e.clr && e.last && neu_rdy, e.clr && e.last));
                        if (e.clr || neu_rdy) begin
                            void'(exp_q.pop_front());
                            stalled = 1'b0;
                        end else begin
                            stalled = 1'b1;
                        end
                    end
                end else begin
                    stalled = 1'b0;
                    check(!scan_done && !clear_done && !scan_start && !neu_last && !neu_clear,
                          "idle_outputs",
                          $sformatf("sd=%0b cd=%0b ss=%0b last=%0b clr=%0b",
                                    scan_done, clear_done, scan_start, neu_last, neu_clear),
                          "all 0");
                end
            end
        end
    endtask

    // Raise tik long enough to fill the synchroniser, then drop it.
    task automatic tik_fall(input bit chk_latency);
        bit ok;
        @(posedge clk); #1;
        tik = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1 tik = 1'b0;
        if (chk_latency) begin
            ok = 1'b1;
            for (int k = 0; k < SYNC - 1; k++) begin
                @(posedge clk); #1;
                ok = ok && !busy;
            end
            @(posedge clk); #1;
            ok = ok && neu_vld;
            check(ok, "start_latency", $sformatf("vld=%0b", neu_vld), "vld rises after SYNC edges");
        end
    endtask

    task automatic wait_busy(input int budget, input string name);
        int n = 0;
        while (!busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(busy, name, "still idle", "busy");
    endtask

    task automatic wait_idle(input int budget, input bit rnd_rdy, input string name);
        int n = 0;
        do begin
            @(posedge clk); #1;
            if (rnd_rdy) neu_rdy = ($urandom_range(0, 3) != 0);
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        check(!busy && exp_q.size() == 0, name,
              $sformatf("busy=%0b pending=%0d", busy, exp_q.size()), "idle, 0 pending");
        exp_q.delete();
        neu_rdy = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, v0, o0, c0, n, cyc, busy_cnt;
        logic [CODE_WIDTH-1:0] code;

        rst = 1'b1; tik = 1'b0; config_enable = 1'b1; config_clear = 1'b0;
        spike_code = CODE_LIF; neu_rdy = 1'b1;
        c_num = 0; c_xo = 0; c_yo = 0; c_zn = 0; c_xs = 0; c_ys = 0; c_zs = 0;
        apply_cfg();
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check(!neu_vld && neu_addr == 0 && neu_mode == 0 && !neu_clear && !neu_last && neu_spkid == 0 &&
              !scan_start && !scan_done && !clear_done && !tik_overrun && !busy,
              "reset_state", $sformatf("vld=%0b addr=%0d mode=%0d busy=%0b", neu_vld, neu_addr, neu_mode, busy),
              "all 0");
        @(negedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;

        $display("[tb] basic 6-neuron scan, 3x2x1 grid, COUNT mode");
        c_num = 5; c_xo = 2; c_yo = 1; c_zn = 0; apply_cfg();
        spike_code = CODE_COUNT;
        d0 = done_seen; v0 = vld_cycles;
        push_scan(CODE_COUNT);
        tik_fall(1'b1);
        wait_idle(100, 1'b0, "basic_scan_end");
        check(done_seen - d0 == 1, "basic_done_count", $sformatf("%0d", done_seen - d0), "1");
        check(vld_cycles - v0 == 6, "basic_vld_cycles", $sformatf("%0d", vld_cycles - v0), "6");

        $display("[tb] same scan with 3 stall cycles at addr 2");
        d0 = done_seen; v0 = vld_cycles;
        push_scan(CODE_COUNT);
        tik_fall(1'b0);
        n = 0;
        while (!(neu_vld && neu_addr == 2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(neu_vld && neu_addr == 2, "stall_reach_addr2", $sformatf("addr=%0d", neu_addr), "addr=2");
        neu_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 neu_rdy = 1'b1;
        wait_idle(100, 1'b0, "stall_scan_end");
        check(vld_cycles - v0 == 9, "stall_vld_cycles", $sformatf("%0d", vld_cycles - v0), "9");
        check(done_seen - d0 == 1, "stall_done_count", $sformatf("%0d", done_seen - d0), "1");

        $display("[tb] z wrap: z_start=255, z_num=2, POISSON mode");
        c_num = 2; c_xo = 0; c_yo = 0; c_zn = 2; c_xs = 7; c_ys = 200; c_zs = 255; apply_cfg();
        spike_code = CODE_POISSON;
        push_scan(CODE_POISSON);
        tik_fall(1'b0);
        wait_idle(100, 1'b0, "wrap_scan_end");

        $display("[tb] three tik falls during one scan: one rescan, one overrun");
        c_num = 23; c_xo = 3; c_yo = 2; c_zn = 1; c_xs = 10; c_ys = 20; c_zs = 30; apply_cfg();
        spike_code = CODE_LIF;
        d0 = done_seen; o0 = ovr_seen;
        push_scan(CODE_LIF);
        push_scan(CODE_LIF);
        tik_fall(1'b0);
        wait_busy(20, "pend_first_start");
        cyc = 0; busy_cnt = 0;
        while (busy && cyc < 200) begin
            if (cyc == 3 || cyc == 9)  tik = 1'b1;
            if (cyc == 6 || cyc == 12) tik = 1'b0;
            busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check(busy_cnt == 48, "pend_no_gap_cycles", $sformatf("%0d", busy_cnt), "48");
        check(done_seen - d0 == 2, "pend_done_count", $sformatf("%0d", done_seen - d0), "2");
        check(ovr_seen - o0 == 1, "overrun_count", $sformatf("%0d", ovr_seen - o0), "1");
        check(exp_q.size() == 0, "pend_all_issued", $sformatf("%0d left", exp_q.size()), "0 left");
        exp_q.delete();

        $display("[tb] clear sweep of 4 addresses");
        config_enable = 1'b0;
        c_num = 3; apply_cfg();
        c0 = cdone_seen;
        push_clear();
        config_clear = 1'b1;
        @(posedge clk); #1 config_clear = 1'b0;
        wait_idle(50, 1'b0, "clear_end");
        check(cdone_seen - c0 == 1, "clear_done_count", $sformatf("%0d", cdone_seen - c0), "1");
        config_enable = 1'b1;

        $display("[tb] abort by config_enable low at addr 2");
        c_num = 9; c_xo = 1; c_yo = 1; c_zn = 3; c_xs = 0; c_ys = 0; c_zs = 0; apply_cfg();
        spike_code = CODE_COUNT;
        d0 = done_seen;
        push_scan(CODE_COUNT);
        tik_fall(1'b0);
        n = 0;
        while (!(neu_vld && neu_addr == 2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(neu_vld && neu_addr == 2, "abort_reach_addr2", $sformatf("addr=%0d", neu_addr), "addr=2");
        config_enable = 1'b0;
        neu_rdy = 1'b0;
        @(posedge clk); #1;
        check(!busy && !neu_vld, "abort_to_idle", $sformatf("busy=%0b", busy), "busy=0");
        @(posedge clk); #1;
        check(done_seen == d0, "abort_no_done", $sformatf("%0d", done_seen - d0), "0");
        exp_q.delete();
        config_enable = 1'b1;
        neu_rdy = 1'b1;

        $display("[tb] reserved spike code never leaves IDLE");
        spike_code = CODE_RESERVED;
        tik_fall(1'b0);
        busy_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        check(busy_cnt == 0, "reserved_stays_idle", $sformatf("%0d busy cycles", busy_cnt), "0");

        $display("[tb] asynchronous reset mid-scan");
        c_num = 15; apply_cfg();
        spike_code = CODE_POISSON;
        push_scan(CODE_POISSON);
        tik_fall(1'b0);
        wait_busy(20, "reset_scan_start");
        repeat (4) @(posedge clk);
        #1 mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check(!neu_vld && !busy && neu_addr == 0 && neu_mode == 0 && neu_spkid == 0 && !neu_last,
              "async_reset", $sformatf("vld=%0b addr=%0d mode=%0d", neu_vld, neu_addr, neu_mode), "all 0");
        @(negedge clk); #1 rst = 1'b0;
        exp_q.delete();
        stalled = 1'b0;
        @(posedge clk); #1 mon_en = 1'b1;

        $display("[tb] randomized scans and clears");
        for (int it = 0; it < 24; it++) begin
            c_num = $urandom_range(0, 15);
            c_xo  = $urandom_range(0, 3);
            c_yo  = $urandom_range(0, 2);
            c_zn  = $urandom_range(0, 2);
            c_xs  = $urandom_range(0, 255);
            c_ys  = $urandom_range(0, 255);
            c_zs  = $urandom_range(0, 255);
            apply_cfg();
            if ($urandom_range(0, 4) == 0) begin
                $display("[tb] random clear %0d: neu_num=%0d", it, c_num);
                config_enable = 1'b0;
                push_clear();
                config_clear = 1'b1;
                @(posedge clk); #1 config_clear = 1'b0;
                wait_idle(100, 1'b0, "rand_clear_end");
                config_enable = 1'b1;
            end else begin
                code = CODE_WIDTH'($urandom_range(0, 2));
                $display("[tb] random scan %0d: neu_num=%0d grid=%0d/%0d/%0d code=%0d",
                         it, c_num, c_xo, c_yo, c_zn, code);
                spike_code = code;
                push_scan(code);
                tik_fall(1'b0);
                wait_busy(20, "rand_scan_start");
                wait_idle(400, 1'b1, "rand_scan_end");
            end
            repeat (2) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
